// File: rtl/rotate_pkg.sv
// Shared types and helpers for the rotation frame-store page scheduler.
package rotate_pkg;

  typedef logic [1:0] page_t;

  localparam int STAT_W = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  function automatic longint unsigned buf_words(input int unsigned width,
                                                input int unsigned height);
    return 64'(width) * 64'(height);
  endfunction

  // Counters stick at STAT_MAX instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cnt,
                                                input logic [1:0] inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, cnt} + (STAT_W+1)'(inc);
    return sum[STAT_W] ? STAT_MAX : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/rotate_page_select.sv
// Picks the lowest page that is neither displayed nor holding the pending frame.
import rotate_pkg::*;

module rotate_page_select #(
  parameter int PAGES = 3
) (
  input  page_t rd_page,
  input  logic  rd_valid,
  input  page_t ready_idx,
  input  logic  ready_valid,
  output page_t sel_page,
  output logic  force_drop
);

  logic found;

  // With only two pages the pending frame may have to be sacrificed.
  always_comb begin
    sel_page   = '0;
    found      = 1'b0;
    force_drop = 1'b0;
    for (int i = 0; i < PAGES; i++) begin
      if (!found &&
          !(rd_valid && rd_page == page_t'(i)) &&
          !(ready_valid && ready_idx == page_t'(i))) begin
        sel_page = page_t'(i);
        found    = 1'b1;
      end
    end
    if (!found) begin
      sel_page   = {1'b0, ~rd_page[0]};
      force_drop = 1'b1;
    end
  end

endmodule

// File: rtl/rotate_page_scheduler.sv
// Page manager for the rotation frame store: grants writer/reader pages,
// keeps the newest completed frame for the reader and counts drops/repeats.
import rotate_pkg::*;

module rotate_page_scheduler #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int AW     = 18,
  parameter int PAGES  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_start,
  input  logic              wr_done,
  output logic              wr_allow,
  output logic [1:0]        wr_page,
  output logic [AW-1:0]     wr_base,
  input  logic              rd_start,
  input  logic              freeze,
  output logic              rd_valid,
  output logic [1:0]        rd_page,
  output logic [AW-1:0]     rd_base,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] drop_cnt,
  output logic [STAT_W-1:0] repeat_cnt
);

  localparam longint unsigned BUF_L   = buf_words(WIDTH, HEIGHT);
  localparam longint unsigned TOTAL_L = 64'(PAGES) * BUF_L;

  localparam logic [AW-1:0] BUF_WORDS  = AW'(BUF_L);
  localparam logic [AW-1:0] HEIGHT_AW  = AW'(HEIGHT);
  localparam logic [AW-1:0] WR_OFFSET  = BUF_WORDS - HEIGHT_AW;
  localparam logic [AW-1:0] PAGE_BASE1 = AW'(BUF_L);
  localparam logic [AW-1:0] PAGE_BASE2 = AW'(64'd2 * BUF_L);

  generate
    if (PAGES != 2 && PAGES != 3) begin : g_bad_pages
      $error("rotate_page_scheduler: PAGES must be 2 or 3");
    end
    if (TOTAL_L > (64'd1 << AW)) begin : g_bad_aw
      $error("rotate_page_scheduler: PAGES*WIDTH*HEIGHT exceeds 2^AW");
    end
  endgenerate

  // Page bases are constant multiples, so a lookup replaces a multiplier.
  function automatic logic [AW-1:0] page_base(input page_t p);
    case (p)
      2'd1:    return PAGE_BASE1;
      2'd2:    return PAGE_BASE2;
      default: return '0;
    endcase
  endfunction

  logic  writing;
  logic  ready_valid;
  page_t ready_idx;

  logic  s1_writing, s1_ready_valid, s1_rd_valid;
  page_t s1_ready_idx, s1_rd_page;
  logic  done_drop, repeat_inc;

  logic  n_writing, n_ready_valid;
  page_t n_wr_page;
  logic  abandon_drop, force_drop_apply;
  logic  [1:0] drop_inc;

  page_t sel_page;
  logic  sel_force_drop;

  assign wr_allow = writing;

  // First half of the cycle: a finishing frame, then the reader's pickup,
  // so the reader can take a frame completed in the same cycle.
  always_comb begin
    s1_writing     = writing;
    s1_ready_valid = ready_valid;
    s1_ready_idx   = ready_idx;
    s1_rd_valid    = rd_valid;
    s1_rd_page     = rd_page;
    done_drop      = 1'b0;
    repeat_inc     = 1'b0;
    if (wr_done && writing) begin
      done_drop      = ready_valid;
      s1_ready_idx   = wr_page;
      s1_ready_valid = 1'b1;
      s1_writing     = 1'b0;
    end
    if (rd_start) begin
      if (!freeze && s1_ready_valid) begin
        s1_rd_page     = s1_ready_idx;
        s1_rd_valid    = 1'b1;
        s1_ready_valid = 1'b0;
      end else begin
        repeat_inc = rd_valid;
      end
    end
  end

  rotate_page_select #(
    .PAGES(PAGES)
  ) u_select (
    .rd_page    (s1_rd_page),
    .rd_valid   (s1_rd_valid),
    .ready_idx  (s1_ready_idx),
    .ready_valid(s1_ready_valid),
    .sel_page   (sel_page),
    .force_drop (sel_force_drop)
  );

  always_comb begin
    n_writing        = s1_writing;
    n_wr_page        = wr_page;
    n_ready_valid    = s1_ready_valid;
    abandon_drop     = 1'b0;
    force_drop_apply = 1'b0;
    if (wr_start) begin
      abandon_drop = s1_writing;
      n_wr_page    = sel_page;
      n_writing    = 1'b1;
      if (sel_force_drop) begin
        n_ready_valid    = 1'b0;
        force_drop_apply = 1'b1;
      end
    end
    drop_inc = 2'(done_drop) + 2'(abandon_drop) + 2'(force_drop_apply);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      writing     <= 1'b0;
      wr_page     <= '0;
      wr_base     <= WR_OFFSET;
      rd_valid    <= 1'b0;
      rd_page     <= '0;
      rd_base     <= '0;
      ready_valid <= 1'b0;
      ready_idx   <= '0;
      drop_cnt    <= '0;
      repeat_cnt  <= '0;
    end else begin
      writing     <= n_writing;
      wr_page     <= n_wr_page;
      wr_base     <= page_base(n_wr_page) + WR_OFFSET;
      rd_valid    <= s1_rd_valid;
      rd_page     <= s1_rd_page;
      rd_base     <= page_base(s1_rd_page);
      ready_valid <= n_ready_valid;
      ready_idx   <= s1_ready_idx;
      if (clr_stats) begin
        drop_cnt   <= '0;
        repeat_cnt <= '0;
      end else begin
        drop_cnt   <= sat_add(drop_cnt, drop_inc);
        repeat_cnt <= sat_add(repeat_cnt, {1'b0, repeat_inc});
      end
    end
  end

endmodule

// File: tb/tb_rotate_page_scheduler.sv
// Bench for rotate_page_scheduler: triple-buffer instance [0], double-buffer instance [1].
module tb_rotate_page_scheduler;

  localparam int BUF_W  = 320 * 240;
  localparam int WR_OFF = BUF_W - 240;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic       ws[2], wd[2], rs[2], fz[2], clr[2];
  logic       wa[2], rdv[2];
  logic [1:0] wp[2], rp[2];
  logic [17:0] wb[2], rb[2];
  logic [7:0] dc[2], rc[2];

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic ws, wd, rs, fz, clr;
    logic wa;
    logic [1:0] wp;
    logic rdv;
    logic [1:0] rp;
    int drop;
    int rep;
  } vec_t;

  typedef struct {
    int tag;
    logic wa;
    logic [1:0] wp;
    logic rdv;
    logic [1:0] rp;
    int drop;
    int rep;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rotate_page_scheduler #(.WIDTH(320), .HEIGHT(240), .AW(18), .PAGES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .wr_start(ws[0]), .wr_done(wd[0]), .wr_allow(wa[0]), .wr_page(wp[0]), .wr_base(wb[0]),
    .rd_start(rs[0]), .freeze(fz[0]), .rd_valid(rdv[0]), .rd_page(rp[0]), .rd_base(rb[0]),
    .clr_stats(clr[0]), .drop_cnt(dc[0]), .repeat_cnt(rc[0])
  );

  rotate_page_scheduler #(.WIDTH(320), .HEIGHT(240), .AW(18), .PAGES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .wr_start(ws[1]), .wr_done(wd[1]), .wr_allow(wa[1]), .wr_page(wp[1]), .wr_base(wb[1]),
    .rd_start(rs[1]), .freeze(fz[1]), .rd_valid(rdv[1]), .rd_page(rp[1]), .rd_base(rb[1]),
    .clr_stats(clr[1]), .drop_cnt(dc[1]), .repeat_cnt(rc[1])
  );

  function automatic vec_t mk(input bit a_ws, input bit a_wd, input bit a_rs, input bit a_fz,
                              input bit a_clr, input bit a_wa, input int a_wp, input bit a_rdv,
                              input int a_rp, input int a_drop, input int a_rep);
    vec_t v;
    v.ws = a_ws; v.wd = a_wd; v.rs = a_rs; v.fz = a_fz; v.clr = a_clr;
    v.wa = a_wa; v.wp = 2'(a_wp); v.rdv = a_rdv; v.rp = 2'(a_rp);
    v.drop = a_drop; v.rep = a_rep;
    return v;
  endfunction

  task automatic cmp(input string name, input int tag, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, tag, act, exp);
  endtask

  task automatic check_output(input int d);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_empty dut %0d: got 0 entries expected 1", d);
      return;
    end
    e = sb.pop_front();
    cmp("wr_allow",   e.tag, wa[d],  e.wa);
    cmp("wr_page",    e.tag, wp[d],  e.wp);
    cmp("wr_base",    e.tag, wb[d],  longint'(e.wp) * BUF_W + WR_OFF);
    cmp("rd_valid",   e.tag, rdv[d], e.rdv);
    cmp("rd_page",    e.tag, rp[d],  e.rp);
    cmp("rd_base",    e.tag, rb[d],  longint'(e.rp) * BUF_W);
    cmp("drop_cnt",   e.tag, dc[d],  e.drop);
    cmp("repeat_cnt", e.tag, rc[d],  e.rep);
  endtask

  task automatic check_reset(input int d, input int tag);
    cmp("rst_wr_allow",   tag, wa[d],  0);
    cmp("rst_wr_page",    tag, wp[d],  0);
    cmp("rst_wr_base",    tag, wb[d],  WR_OFF);
    cmp("rst_rd_valid",   tag, rdv[d], 0);
    cmp("rst_rd_page",    tag, rp[d],  0);
    cmp("rst_rd_base",    tag, rb[d],  0);
    cmp("rst_drop_cnt",   tag, dc[d],  0);
    cmp("rst_repeat_cnt", tag, rc[d],  0);
  endtask

  task automatic apply_stimulus(input int d, input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    ws[d] = v.ws; wd[d] = v.wd; rs[d] = v.rs; fz[d] = v.fz; clr[d] = v.clr;
    e.tag = tag; e.wa = v.wa; e.wp = v.wp; e.rdv = v.rdv; e.rp = v.rp;
    e.drop = v.drop; e.rep = v.rep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ws[d] = 1'b0; wd[d] = 1'b0; rs[d] = 1'b0; fz[d] = 1'b0; clr[d] = 1'b0;
    check_output(d);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    vec_t ta[21];
    vec_t tb2[10];
    vec_t tr[4];
    int exp_rep;

    for (int d = 0; d < 2; d++) begin
      ws[d] = 1'b0; wd[d] = 1'b0; rs[d] = 1'b0; fz[d] = 1'b0; clr[d] = 1'b0;
    end

    //          ws wd rs fz clr  wa wp rdv rp drop rep
    ta[0]  = mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    ta[1]  = mk(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    ta[2]  = mk(1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
    ta[3]  = mk(0, 1, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    ta[4]  = mk(0, 0, 1, 0, 0,   0, 1, 1, 1, 1, 0);
    ta[5]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 1, 1, 0);
    ta[6]  = mk(0, 1, 1, 0, 0,   0, 0, 1, 0, 1, 0);
    ta[7]  = mk(0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 1);
    ta[8]  = mk(1, 0, 0, 0, 0,   1, 1, 1, 0, 1, 1);
    ta[9]  = mk(1, 0, 0, 0, 0,   1, 1, 1, 0, 2, 1);
    ta[10] = mk(0, 1, 0, 0, 0,   0, 1, 1, 0, 2, 1);
    ta[11] = mk(0, 0, 1, 1, 0,   0, 1, 1, 0, 2, 2);
    ta[12] = mk(1, 0, 0, 0, 0,   1, 2, 1, 0, 2, 2);
    ta[13] = mk(0, 1, 0, 0, 0,   0, 2, 1, 0, 3, 2);
    ta[14] = mk(1, 0, 1, 1, 0,   1, 1, 1, 0, 3, 3);
    ta[15] = mk(0, 1, 1, 1, 0,   0, 1, 1, 0, 4, 4);
    ta[16] = mk(0, 0, 1, 0, 0,   0, 1, 1, 1, 4, 4);
    ta[17] = mk(0, 0, 0, 0, 1,   0, 1, 1, 1, 0, 0);
    ta[18] = mk(0, 0, 1, 0, 1,   0, 1, 1, 1, 0, 0);
    ta[19] = mk(1, 1, 1, 0, 0,   1, 0, 1, 1, 0, 1);
    ta[20] = mk(1, 1, 1, 0, 0,   1, 1, 1, 0, 0, 1);

    tb2[0] = mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tb2[1] = mk(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tb2[2] = mk(0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
    tb2[3] = mk(1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0);
    tb2[4] = mk(0, 1, 0, 0, 0,   0, 1, 1, 0, 0, 0);
    tb2[5] = mk(1, 0, 0, 0, 0,   1, 1, 1, 0, 1, 0);
    tb2[6] = mk(0, 1, 0, 0, 0,   0, 1, 1, 0, 1, 0);
    tb2[7] = mk(0, 0, 1, 0, 0,   0, 1, 1, 1, 1, 0);
    tb2[8] = mk(1, 0, 0, 0, 0,   1, 0, 1, 1, 1, 0);
    tb2[9] = mk(0, 0, 1, 0, 0,   1, 0, 1, 1, 1, 1);

    tr[0]  = mk(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    tr[1]  = mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tr[2]  = mk(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tr[3]  = mk(0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0);

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0, 0);
    check_reset(1, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] triple-buffer table");
    for (int i = 0; i < 21; i++) apply_stimulus(0, ta[i], i + 1);

    $display("[TB] double-buffer table");
    for (int i = 0; i < 10; i++) apply_stimulus(1, tb2[i], 100 + i);

    // Reader keeps restarting with nothing new: repeat counter saturates.
    $display("[TB] repeat saturation");
    exp_rep = 1;
    for (int i = 0; i < 300; i++) begin
      exp_rep = (exp_rep < 255) ? exp_rep + 1 : 255;
      apply_stimulus(0, mk(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, exp_rep), 200 + i);
    end
    apply_stimulus(0, mk(0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0), 600);

    // Reset dropped mid-frame, away from any clock edge.
    $display("[TB] asynchronous reset mid-write");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset(0, 700);
    check_reset(1, 700);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(0, tr[i], 800 + i);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
